// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM state codes, register map, CON bit positions.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_CON = 32'h4000_0020;

   localparam int unsigned CON_IRQ_EN = 0;
   localparam int unsigned CON_FULL   = 1;
   localparam int unsigned CON_DONE   = 2;
   localparam int unsigned CON_OVF    = 3;
   localparam int unsigned CON_BUSY   = 4;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick on the final count; held at 0 by restart.
module uart_baud_tick #(
   parameter int unsigned DIV = 16
) (
   input  logic sysclk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      if (restart || cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter with TX FIFO and frame-done interrupt.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        UART_TX,
   output logic        irq
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);

   logic       txd_hit, con_hit, push, push_ok, pop, con_wr, con_rd;
   logic       empty, full, busy, tick, restart;
   logic       done_set, ovf_set;
   logic       irq_en_q, done_q, ovf_q;
   logic [7:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   count_q, count_d;
   logic [2:0] state_q, state_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       tx_q, tx_d;
   logic       unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   assign txd_hit = (addr == ADDR_TXD);
   assign con_hit = (addr == ADDR_CON);
   assign push    = wr & txd_hit;
   assign con_wr  = wr & con_hit;
   assign con_rd  = rd & con_hit;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
   assign restart = (state_q == ST_IDLE);
   // A pop frees a slot before the push is judged, so push into a full FIFO can still land
   assign pop     = !empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && tick));
   assign push_ok = push && (!full || pop);
   assign ovf_set = push && !push_ok;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud (
      .sysclk  (sysclk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      done_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               state_d = ST_START;
               shift_d = fifo_mem[rptr_q];
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = ^shift_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[bit_idx_q + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               done_set = 1'b1;
               // Back-to-back frames: next start bit follows the stop bit with no idle gap
               if (!empty) begin
                  state_d = ST_START;
                  shift_d = fifo_mem[rptr_q];
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (push_ok) begin
         fifo_mem[wptr_q] <= wdata[7:0];
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         state_q   <= ST_IDLE;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         count_q   <= count_d;
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         if (con_wr) irq_en_q <= wdata[0];
         done_q    <= done_set | (done_q & !con_rd);
         ovf_q     <= ovf_set | (ovf_q & !con_rd);
      end
   end

   assign busy = (state_q != ST_IDLE) || !empty;

   always_comb begin
      rdata = 32'd0;
      if (con_rd) begin
         rdata[CON_IRQ_EN] = irq_en_q;
         rdata[CON_FULL]   = full;
         rdata[CON_DONE]   = done_q;
         rdata[CON_OVF]    = ovf_q;
         rdata[CON_BUSY]   = busy;
      end
   end

   assign UART_TX = tx_q;
   assign irq     = irq_en_q & done_q;

endmodule
